// File: rtl/feature_ssd_accum.sv
// Streaming sum-of-squared-differences accumulator: |a-b| -> square -> saturating accumulate,
// with valid/ready handshakes on the sample input and the result output.
module feature_ssd_accum #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned VEC_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [31:0]       sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);
  localparam int unsigned SqW  = 2 * DATA_W;
  localparam logic [CntW-1:0] LastCnt = CntW'(VEC_LEN - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] diff_q, diff_d;
  logic              s2_valid_q, s2_valid_d;
  logic [SqW-1:0]    sq_q, sq_d;
  logic [31:0]       acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              sum_valid_q, sum_valid_d;
  logic              accept;
  logic [32:0]       sum_wide;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    s1_valid_d = accept;
    diff_d     = diff_q;
    s2_valid_d = s1_valid_q;
    sq_d       = SqW'(diff_q) * SqW'(diff_q);
    sum_wide   = {1'b0, acc_q} + 33'(sq_q);

    if (accept) begin
      diff_d = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
    end

    // Once saturated, stay pinned at all-ones for the rest of the vector.
    if (s2_valid_q) begin
      if (sum_wide[32] || ovf_q) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_wide[31:0];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          count_d = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StAccum: begin
        if (accept) begin
          count_d = count_q + CntW'(1);
          if (count_q == LastCnt) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (sum_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StAccum);
    busy_d      = (state_d != StIdle);
    sum_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      diff_q      <= '0;
      s2_valid_q  <= 1'b0;
      sq_q        <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      diff_q      <= diff_d;
      s2_valid_q  <= s2_valid_d;
      sq_q        <= sq_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;
  assign sum_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_feature_ssd_accum.sv
// Randomized self-checking bench for feature_ssd_accum against a plain-arithmetic SSD model.
module tb_feature_ssd_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_ready, sum_valid, sum_ready, busy, overflow;
  logic [7:0]  in_a, in_b;
  logic [31:0] sum_out;

  logic        start_w, in_valid_w, in_ready_w, sum_valid_w, sum_ready_w, busy_w, overflow_w;
  logic [15:0] in_a_w, in_b_w;
  logic [31:0] sum_out_w;

  int checks = 0;
  int failures = 0;
  int unsigned va[64];
  int unsigned vb[64];

  always #5 clk = ~clk;

  feature_ssd_accum #(.DATA_W(8), .VEC_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .overflow(overflow)
  );

  feature_ssd_accum #(.DATA_W(16), .VEC_LEN(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_a(in_a_w), .in_b(in_b_w), .sum_out(sum_out_w), .sum_valid(sum_valid_w),
    .sum_ready(sum_ready_w), .busy(busy_w), .overflow(overflow_w)
  );

  // Reference: exact sum of squared differences of the first n stored pairs.
  function automatic longint unsigned model_ssd(input int n);
    longint unsigned s;
    longint unsigned d;
    s = 0;
    for (int i = 0; i < n; i++) begin
      d = (va[i] >= vb[i]) ? longint'(va[i] - vb[i]) : longint'(vb[i] - va[i]);
      s += d * d;
    end
    return s;
  endfunction

  // Runs one 64-sample vector on the 8-bit DUT and leaves it in HOLD.
  task automatic run8(input int bubble_pct, input string name);
    int idx, guard, k;
    logic rdy;
    longint unsigned exp_full;
    logic [31:0] exp_sum;
    logic exp_ovf;
    exp_full = model_ssd(64);
    exp_ovf  = (exp_full > 64'hFFFF_FFFF);
    exp_sum  = exp_ovf ? 32'hFFFF_FFFF : exp_full[31:0];
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_a = 8'(va[0]); in_b = 8'(vb[0]);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL %s idle_in_ready got=%b want=0", name, in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s accum_entry in_ready=%b busy=%b want=1,1", name, in_ready, busy);
    end
    idx = 0; guard = 0;
    while (idx < 64 && guard < 4000) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_a = 8'(va[idx]); in_b = 8'(vb[idx]);
      rdy = in_ready;
      @(posedge clk); #1;
      guard++;
      if (in_valid && rdy) idx++;
    end
    checks++;
    if (idx != 64) begin
      failures++; $display("FAIL %s accept_timeout got=%0d want=64", name, idx);
    end
    // Garbage offered after the last accept must be ignored.
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL %s in_ready_after_last got=%b want=0", name, in_ready);
    end
    k = 0;
    while (sum_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 3) begin
      failures++; $display("FAIL %s latency got=%0d want=3", name, k);
    end
    checks++;
    if (sum_out !== exp_sum) begin
      failures++; $display("FAIL %s sum got=%0d want=%0d", name, sum_out, exp_sum);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      failures++; $display("FAIL %s overflow got=%b want=%b", name, overflow, exp_ovf);
    end
  endtask

  task automatic consume8(input string name);
    logic [31:0] held;
    held = sum_out;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum_out !== held) begin
      failures++;
      $display("FAIL %s consume sum_valid=%b busy=%b sum=%0d want 0,0,%0d",
               name, sum_valid, busy, sum_out, held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || sum_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        sum_out !== 32'd0) begin
      failures++;
      $display("FAIL reset rdy=%b sv=%b busy=%b ovf=%b sum=%0d want all 0",
               in_ready, sum_valid, busy, overflow, sum_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_equal();
    for (int i = 0; i < 64; i++) begin va[i] = 37; vb[i] = 37; end
    run8(0, "equal");
    consume8("equal");
  endtask

  task automatic test_max();
    for (int i = 0; i < 64; i++) begin va[i] = 255; vb[i] = 0; end
    run8(0, "max");
    checks++;
    if (sum_out !== 32'h003F_8040) begin
      failures++; $display("FAIL max_const got=%h want=003f8040", sum_out);
    end
    consume8("max");
  endtask

  task automatic test_ramp_bubbles();
    for (int i = 0; i < 64; i++) begin va[i] = i; vb[i] = 0; end
    run8(35, "ramp");
    checks++;
    if (sum_out !== 32'd85344) begin
      failures++; $display("FAIL ramp_const got=%0d want=85344", sum_out);
    end
    consume8("ramp");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) begin
        va[i] = $urandom_range(255); vb[i] = $urandom_range(255);
      end
      run8(r * 20, "random");
      consume8("random");
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    for (int i = 0; i < 64; i++) begin
      va[i] = $urandom_range(255); vb[i] = $urandom_range(255);
    end
    run8(10, "hold");
    held = sum_out;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      @(posedge clk); #1;
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== held || busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable c=%0d sv=%b sum=%0d busy=%b rdy=%b want 1,%0d,1,0",
                 c, sum_valid, sum_out, busy, in_ready, held);
      end
    end
    start = 1'b0;
    consume8("hold");
  endtask

  task automatic test_saturation();
    int k;
    for (int run = 0; run < 2; run++) begin
      @(posedge clk); #1;
      start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      if (run == 1) begin
        checks++;
        if (overflow_w !== 1'b0) begin
          failures++; $display("FAIL sat_clear got=%b want=0", overflow_w);
        end
      end
      for (int i = 0; i < 4; i++) begin
        va[i] = (run == 0) ? 65535 : $urandom_range(4000);
        vb[i] = (run == 0) ? 0 : $urandom_range(4000);
      end
      in_valid_w = 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_a_w = 16'(va[i]); in_b_w = 16'(vb[i]);
        @(posedge clk); #1;
      end
      in_valid_w = 1'b0;
      k = 0;
      while (sum_valid_w !== 1'b1 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      checks++;
      if (k != 3) begin
        failures++; $display("FAIL sat_latency run=%0d got=%0d want=3", run, k);
      end
      checks++;
      if (run == 0 && (sum_out_w !== 32'hFFFF_FFFF || overflow_w !== 1'b1)) begin
        failures++;
        $display("FAIL sat_result got=%h ovf=%b want=ffffffff ovf=1", sum_out_w, overflow_w);
      end else if (run == 1 && (sum_out_w !== 32'(model_ssd(4)) || overflow_w !== 1'b0)) begin
        failures++;
        $display("FAIL sat_rerun got=%0d ovf=%b want=%0d ovf=0",
                 sum_out_w, overflow_w, model_ssd(4));
      end
      sum_ready_w = 1'b1;
      @(posedge clk); #1;
      sum_ready_w = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd3;
    idx = 0;
    while (idx < 20) begin
      @(posedge clk); #1;
      idx++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || sum_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        sum_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid rdy=%b sv=%b busy=%b ovf=%b sum=%0d want all 0",
               in_ready, sum_valid, busy, overflow, sum_out);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      va[i] = $urandom_range(255); vb[i] = $urandom_range(255);
    end
    run8(15, "after_reset");
    consume8("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; sum_ready = 1'b0;
    start_w = 1'b0; in_valid_w = 1'b0; in_a_w = '0; in_b_w = '0; sum_ready_w = 1'b0;
    test_reset();
    test_equal();
    test_max();
    test_ramp_bubbles();
    test_random();
    test_hold();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
